// File: rtl/coin_acceptor_frontend.sv
// Coin-slot front end: sync + debounce two sensors, queue coins, pace credit pulses.
// Ports: clk, reset (async active-low), raw_coin5/raw_coin10 (async sensors), accept_en (consumer ready);
//        coin5/coin10/reject single-cycle pulses, fifo_full/fifo_count registered queue status.
module coin_acceptor_frontend #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int FIFO_DEPTH      = 4,
   parameter int COUNT_W         = 3,
   parameter int GAP_CYCLES      = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               raw_coin5,
   input  logic               raw_coin10,
   input  logic               accept_en,
   output logic               coin5,
   output logic               coin10,
   output logic               reject,
   output logic               fifo_full,
   output logic [COUNT_W-1:0] fifo_count
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int AW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int GW   = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   // Channel index 0 = coin5, 1 = coin10 throughout.
   logic [1:0]            meta;
   logic [1:0]            sync;
   logic [1:0]            deb;
   logic [1:0]            deb_prev;
   logic [1:0]            evt;
   logic [1:0][DB_W-1:0]  db_cnt;

   logic [FIFO_DEPTH-1:0] mem;
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [COUNT_W-1:0]    count_next;
   logic                  pulse_bit;
   logic [GW-1:0]         gap_cnt;

   state_t state;
   state_t state_next;
   logic   push;
   logic   pop;
   logic   reject_next;
   logic   gap_last;
   logic   can_pop;

   // Synchroniser, debounce and rising-edge event detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         meta     <= '0;
         sync     <= '0;
         deb      <= '0;
         deb_prev <= '0;
         evt      <= '0;
         db_cnt   <= '0;
      end else begin
         meta     <= {raw_coin10, raw_coin5};
         sync     <= meta;
         deb_prev <= deb;
         evt      <= deb & ~deb_prev;
         for (int ch = 0; ch < 2; ch++) begin
            if (sync[ch] == deb[ch]) begin
               db_cnt[ch] <= '0;
            end else if (db_cnt[ch] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               // This is the DEBOUNCE_CYCLES-th consecutive mismatching cycle.
               deb[ch]    <= sync[ch];
               db_cnt[ch] <= '0;
            end else begin
               db_cnt[ch] <= db_cnt[ch] + 1'b1;
            end
         end
      end
   end

   // Push / reject decision; fullness is the registered value, i.e. before any same-cycle pop.
   always_comb begin
      push        = (evt[0] ^ evt[1]) & ~fifo_full;
      reject_next = (evt[0] & evt[1]) | ((evt[0] ^ evt[1]) & fifo_full);
      count_next  = fifo_count;
      if (push && !pop) begin
         count_next = fifo_count + COUNT_W'(1);
      end else if (pop && !push) begin
         count_next = fifo_count - COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem        <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         fifo_full  <= 1'b0;
         reject     <= 1'b0;
         pulse_bit  <= 1'b0;
      end else begin
         reject     <= reject_next;
         fifo_count <= count_next;
         fifo_full  <= (count_next == COUNT_W'(FIFO_DEPTH));
         if (push) begin
            mem[wr_ptr] <= evt[1];
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            pulse_bit <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1'b1;
         end
      end
   end

   // Output pacing FSM.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         gap_cnt <= '0;
      end else begin
         state <= state_next;
         if (state == GAP && !gap_last) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end
      end
   end

   always_comb begin
      state_next = state;
      pop        = 1'b0;
      coin5      = 1'b0;
      coin10     = 1'b0;
      can_pop    = (fifo_count != '0) && accept_en;
      gap_last   = (gap_cnt == GW'(GAP_CYCLES - 1));
      case (state)
         IDLE: begin
            if (can_pop) begin
               pop        = 1'b1;
               state_next = PULSE;
            end
         end
         PULSE: begin
            // Outputs decode straight from state so a reset kills the pulse at once.
            coin5      = ~pulse_bit;
            coin10     = pulse_bit;
            state_next = GAP;
         end
         GAP: begin
            // The last gap cycle also makes the idle decision, so back-to-back
            // credits land exactly GAP_CYCLES+1 cycles apart.
            if (gap_last) begin
               if (can_pop) begin
                  pop        = 1'b1;
                  state_next = PULSE;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule
